// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the N-digit BCD game timer.
//   bcd_digit_t    : one packed BCD digit
//   timer_state_t  : IDLE / RUNNING / PAUSED / EXPIRED
//   BCD_MAX_DIGIT  : largest legal BCD digit value
//   is_valid_bcd() : true when a nibble is a legal BCD digit
package bcd_timer_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  function automatic logic is_valid_bcd(input bcd_digit_t d);
    return (d <= BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_timer_nd_digit_cell.sv
// bcd_digit_cell: one combinational BCD digit of the timer datapath.
// The digit is first decremented (when borrow_in is set), then the add
// nibble plus carry_in is added to the decremented value.
// Ports:
//   digit      in  current BCD digit
//   borrow_in  in  decrement request from the lower digit (or the tick)
//   add        in  bonus nibble for this digit
//   carry_in   in  carry from the lower digit's add
//   next_digit out resulting BCD digit
//   borrow_out out borrow into the next digit (digit was 0 and decremented)
//   carry_out  out decimal carry into the next digit
module bcd_digit_cell
  import bcd_timer_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       borrow_in,
  input  logic [3:0] add,
  input  logic       carry_in,
  output logic [3:0] next_digit,
  output logic       borrow_out,
  output logic       carry_out
);

  logic [3:0] dec;
  logic [4:0] sum;

  always_comb begin
    borrow_out = borrow_in && (digit == 4'd0);
    if (!borrow_in)
      dec = digit;
    else if (digit == 4'd0)
      dec = BCD_MAX_DIGIT;
    else
      dec = digit - 4'd1;

    // Max is 9 + 9 + 1 = 19, so a single -10 correction suffices.
    sum = {1'b0, dec} + {1'b0, add} + {4'd0, carry_in};
    if (sum > 5'd9) begin
      next_digit = 4'(sum - 5'd10);
      carry_out  = 1'b1;
    end else begin
      next_digit = sum[3:0];
      carry_out  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_timer_nd.sv
// bcd_timer_nd: N-digit BCD game countdown timer with run/pause/expire
// control, saturating BCD bonus add, low-time warning and a one-cycle
// terminal-count pulse.
// Ports:
//   clk         in  system clock
//   resetN      in  asynchronous active-low reset
//   loadN       in  synchronous active-low reload of INIT_VAL (highest priority)
//   start       in  IDLE -> RUNNING
//   pause_tgl   in  RUNNING <-> PAUSED
//   tick        in  1 Hz strobe, decrements while RUNNING
//   bonus_valid in  add bonus_bcd this cycle (RUNNING/PAUSED only)
//   bonus_bcd   in  BCD bonus seconds
//   count       out packed BCD count, digit 0 in [3:0]
//   tc          out one-cycle pulse on expiry
//   expired     out high in EXPIRED
//   running     out high in RUNNING
//   warn        out low-time warning (combinational)
//   warn_blink  out only with BCD_TIMER_BLINK_EN: toggles per tick while warn
// Optional feature macro: BCD_TIMER_BLINK_EN
module bcd_timer_nd
  import bcd_timer_pkg::*;
#(
  parameter int              DIGITS   = 3,
  parameter logic [4*DIGITS-1:0] INIT_VAL = 12'h120,
  parameter logic [4*DIGITS-1:0] WARN_VAL = 12'h010
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  loadN,
  input  logic                  start,
  input  logic                  pause_tgl,
  input  logic                  tick,
  input  logic                  bonus_valid,
  input  logic [4*DIGITS-1:0]   bonus_bcd,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  expired,
  output logic                  running,
  output logic                  warn
`ifdef BCD_TIMER_BLINK_EN
  ,output logic                 warn_blink
`endif
);

  localparam int CW = 4*DIGITS;
  localparam logic [CW-1:0] ALL_NINES = {DIGITS{BCD_MAX_DIGIT}};

  timer_state_t  state;
  logic          bonus_ok;
  logic          dec_en;
  logic          bonus_en;
  logic          update;
  logic [CW-1:0] sum_count;
  logic [CW-1:0] next_count;
  logic [DIGITS:0] borrow_chain;
  logic [DIGITS:0] carry_chain;

  always_comb begin
    bonus_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (!is_valid_bcd(bonus_bcd[4*i +: 4])) bonus_ok = 1'b0;
  end

  assign dec_en   = tick && (state == RUNNING);
  assign bonus_en = bonus_valid && bonus_ok &&
                    ((state == RUNNING) || (state == PAUSED));
  assign update   = dec_en || bonus_en;

  // Decrement enters at digit 0 via the borrow chain; the add then runs
  // through the carry chain on the already-decremented digits.
  assign borrow_chain[0] = dec_en;
  assign carry_chain[0]  = 1'b0;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .digit      (count[4*i +: 4]),
      .borrow_in  (borrow_chain[i]),
      .add        (bonus_en ? bonus_bcd[4*i +: 4] : 4'd0),
      .carry_in   (carry_chain[i]),
      .next_digit (sum_count[4*i +: 4]),
      .borrow_out (borrow_chain[i+1]),
      .carry_out  (carry_chain[i+1])
    );
  end

  // Carry out of the top digit saturates; a top borrow (decrement of zero)
  // cannot occur while RUNNING but is clamped to zero defensively.
  always_comb begin
    if (carry_chain[DIGITS])
      next_count = ALL_NINES;
    else if (borrow_chain[DIGITS])
      next_count = '0;
    else
      next_count = sum_count;
  end

  assign warn = ((state == RUNNING) || (state == PAUSED)) &&
                (count != '0) && (count <= WARN_VAL);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      count   <= INIT_VAL;
      tc      <= 1'b0;
      expired <= 1'b0;
      running <= 1'b0;
`ifdef BCD_TIMER_BLINK_EN
      warn_blink <= 1'b0;
`endif
    end else if (!loadN) begin
      state   <= IDLE;
      count   <= INIT_VAL;
      tc      <= 1'b0;
      expired <= 1'b0;
      running <= 1'b0;
`ifdef BCD_TIMER_BLINK_EN
      warn_blink <= 1'b0;
`endif
    end else begin
      tc <= 1'b0;
`ifdef BCD_TIMER_BLINK_EN
      warn_blink <= warn ? (warn_blink ^ dec_en) : 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              state   <= EXPIRED;
              tc      <= 1'b1;
              expired <= 1'b1;
`ifdef BCD_TIMER_BLINK_EN
              warn_blink <= 1'b1;
`endif
            end else begin
              state   <= RUNNING;
              running <= 1'b1;
            end
          end
        end
        RUNNING: begin
          if (update) count <= next_count;
          if (update && (next_count == '0)) begin
            state   <= EXPIRED;
            tc      <= 1'b1;
            expired <= 1'b1;
            running <= 1'b0;
`ifdef BCD_TIMER_BLINK_EN
            warn_blink <= 1'b1;
`endif
          end else if (pause_tgl) begin
            state   <= PAUSED;
            running <= 1'b0;
          end
        end
        PAUSED: begin
          if (bonus_en) count <= next_count;
          if (pause_tgl) begin
            state   <= RUNNING;
            running <= 1'b1;
          end
        end
        default: begin
`ifdef BCD_TIMER_BLINK_EN
          warn_blink <= 1'b1;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_timer_nd.sv
module tb_bcd_timer_nd;

  localparam int INIT_S = 120;
  localparam int WARN_S = 10;
  localparam int MAX_S  = 999;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAU = 2, S_EXP = 3;

  logic        clk;
  logic        resetN, loadN, start, pause_tgl, tick, bonus_valid;
  logic [11:0] bonus_bcd;
  logic [11:0] count;
  logic        tc, expired, running, warn;
`ifdef BCD_TIMER_BLINK_EN
  logic        warn_blink;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: time kept as a plain integer number of seconds.
  int   m_val;
  int   m_st;
  logic m_tc;

  bcd_timer_nd #(.DIGITS(3), .INIT_VAL(12'h120), .WARN_VAL(12'h010)) dut (
    .clk(clk), .resetN(resetN), .loadN(loadN), .start(start),
    .pause_tgl(pause_tgl), .tick(tick), .bonus_valid(bonus_valid),
    .bonus_bcd(bonus_bcd), .count(count), .tc(tc), .expired(expired),
    .running(running), .warn(warn)
`ifdef BCD_TIMER_BLINK_EN
    , .warn_blink(warn_blink)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int t;
    t = v;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic bcd_ok(input logic [11:0] b);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) if (b[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic int bcd_int(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic m_warn();
    return ((m_st == S_RUN) || (m_st == S_PAU)) && (m_val != 0) && (m_val <= WARN_S);
  endfunction

  task automatic model_reset();
    m_val = INIT_S; m_st = S_IDLE; m_tc = 1'b0;
  endtask

  task automatic model_step(input logic ld, st, pt, tk, bv, input logic [11:0] bb);
    logic acc_b, upd;
    acc_b = bv && bcd_ok(bb);
    m_tc = 1'b0;
    if (!ld) begin
      m_val = INIT_S; m_st = S_IDLE;
    end else begin
      case (m_st)
        S_IDLE: if (st) begin
          if (m_val == 0) begin m_st = S_EXP; m_tc = 1'b1; end
          else m_st = S_RUN;
        end
        S_RUN: begin
          upd = tk || acc_b;
          if (upd) begin
            m_val = m_val - (tk ? 1 : 0) + (acc_b ? bcd_int(bb) : 0);
            if (m_val > MAX_S) m_val = MAX_S;
          end
          if (upd && m_val == 0) begin m_st = S_EXP; m_tc = 1'b1; end
          else if (pt) m_st = S_PAU;
        end
        S_PAU: begin
          if (acc_b) begin
            m_val = m_val + bcd_int(bb);
            if (m_val > MAX_S) m_val = MAX_S;
          end
          if (pt) m_st = S_RUN;
        end
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of inputs, step the model, return #1 after the edge.
  task automatic apply(input logic ld, st, pt, tk, bv, input logic [11:0] bb);
    loadN = ld; start = st; pause_tgl = pt; tick = tk;
    bonus_valid = bv; bonus_bcd = bb;
    @(posedge clk);
    #1;
    model_step(ld, st, pt, tk, bv, bb);
    loadN = 1'b1; start = 1'b0; pause_tgl = 1'b0; tick = 1'b0;
    bonus_valid = 1'b0; bonus_bcd = '0;
  endtask

  task automatic ticks(input int n);
    repeat (n) apply(1, 0, 0, 1, 0, 12'h000);
  endtask

  task automatic test_reset();
    resetN = 1'b0; loadN = 1'b1; start = 1'b0; pause_tgl = 1'b0;
    tick = 1'b0; bonus_valid = 1'b0; bonus_bcd = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++; if (count !== 12'h120) begin failures++; $display("FAIL reset_count got=%h exp=120", count); end
    checks++; if ({tc, expired, running, warn} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {tc, expired, running, warn}); end
    resetN = 1'b1;
  endtask

  task automatic test_countdown();
    apply(1, 1, 0, 0, 0, 12'h000);
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL start_running got=%b exp=1", running); end
    apply(1, 0, 0, 1, 0, 12'h000);
    checks++; if (count !== 12'h119) begin failures++; $display("FAIL tick1 got=%h exp=119", count); end
    apply(1, 0, 0, 1, 0, 12'h000);
    checks++; if (count !== 12'h118) begin failures++; $display("FAIL tick2 got=%h exp=118", count); end
    apply(1, 0, 0, 1, 0, 12'h000);
    checks++; if (count !== 12'h117 || tc !== 1'b0 || running !== 1'b1) begin failures++; $display("FAIL tick3 got=%h tc=%b run=%b exp=117 tc=0 run=1", count, tc, running); end
  endtask

  task automatic test_borrow_warn();
    ticks(17);
    checks++; if (count !== 12'h100) begin failures++; $display("FAIL reach100 got=%h exp=100", count); end
    ticks(1);
    checks++; if (count !== 12'h099) begin failures++; $display("FAIL borrow got=%h exp=099", count); end
    ticks(88);
    checks++; if (count !== 12'h011 || warn !== 1'b0) begin failures++; $display("FAIL warn011 got=%h warn=%b exp=011 warn=0", count, warn); end
    ticks(1);
    checks++; if (count !== 12'h010 || warn !== 1'b1) begin failures++; $display("FAIL warn010 got=%h warn=%b exp=010 warn=1", count, warn); end
  endtask

  task automatic test_expiry();
    ticks(9);
    checks++; if (count !== 12'h001 || warn !== 1'b1) begin failures++; $display("FAIL reach001 got=%h warn=%b exp=001 warn=1", count, warn); end
    ticks(1);
    checks++; if ({count, tc, expired, running} !== {12'h000, 3'b110}) begin failures++; $display("FAIL expire got=%h tc=%b exp_o=%b run=%b exp=000 1 1 0", count, tc, expired, running); end
    apply(1, 0, 0, 0, 0, 12'h000);
    checks++; if (tc !== 1'b0 || expired !== 1'b1) begin failures++; $display("FAIL tc_pulse got tc=%b expired=%b exp tc=0 expired=1", tc, expired); end
    apply(1, 1, 1, 1, 1, 12'h005);
    checks++; if ({count, tc, expired, warn} !== {12'h000, 3'b010}) begin failures++; $display("FAIL expired_hold got=%h tc=%b exp_o=%b warn=%b exp=000 0 1 0", count, tc, expired, warn); end
  endtask

  task automatic test_pause();
    apply(0, 0, 0, 0, 0, 12'h000);
    checks++; if (count !== 12'h120 || expired !== 1'b0) begin failures++; $display("FAIL load_after_exp got=%h expired=%b exp=120 0", count, expired); end
    apply(1, 1, 0, 0, 0, 12'h000);
    ticks(70);
    apply(1, 0, 1, 0, 0, 12'h000);
    ticks(5);
    checks++; if (count !== 12'h050 || running !== 1'b0) begin failures++; $display("FAIL paused_hold got=%h run=%b exp=050 0", count, running); end
    apply(1, 0, 1, 0, 0, 12'h000);
    ticks(1);
    checks++; if (count !== 12'h049 || running !== 1'b1) begin failures++; $display("FAIL resume got=%h run=%b exp=049 1", count, running); end
  endtask

  task automatic test_bonus();
    apply(1, 0, 0, 0, 1, 12'h946);
    checks++; if (count !== 12'h995) begin failures++; $display("FAIL bonus_add got=%h exp=995", count); end
    apply(1, 0, 0, 0, 1, 12'h010);
    checks++; if (count !== 12'h999) begin failures++; $display("FAIL bonus_sat got=%h exp=999", count); end
    apply(0, 0, 0, 0, 0, 12'h000);
    apply(1, 1, 0, 0, 0, 12'h000);
    ticks(115);
    apply(1, 0, 0, 0, 1, 12'h0A0);
    checks++; if (count !== 12'h005) begin failures++; $display("FAIL bonus_invalid got=%h exp=005", count); end
    ticks(4);
    apply(1, 0, 0, 1, 1, 12'h005);
    checks++; if ({count, tc, expired} !== {12'h005, 2'b00}) begin failures++; $display("FAIL tick_bonus got=%h tc=%b exp_o=%b exp=005 0 0", count, tc, expired); end
  endtask

  task automatic test_midrun_load();
    apply(0, 0, 0, 0, 0, 12'h000);
    apply(1, 1, 0, 0, 0, 12'h000);
    ticks(87);
    checks++; if (count !== 12'h033) begin failures++; $display("FAIL reach033 got=%h exp=033", count); end
    apply(0, 0, 0, 1, 1, 12'h001);
    checks++; if ({count, running, warn} !== {12'h120, 2'b00}) begin failures++; $display("FAIL midrun_load got=%h run=%b warn=%b exp=120 0 0", count, running, warn); end
    apply(1, 0, 0, 1, 0, 12'h000);
    checks++; if (count !== 12'h120) begin failures++; $display("FAIL idle_after_load got=%h exp=120", count); end
  endtask

  task automatic test_async_reset();
    apply(1, 1, 0, 0, 0, 12'h000);
    ticks(120);
    checks++; if (tc !== 1'b1 || expired !== 1'b1) begin failures++; $display("FAIL pre_reset got tc=%b expired=%b exp 1 1", tc, expired); end
    resetN = 1'b0;
    #1;
    model_reset();
    checks++; if ({count, tc, expired, running} !== {12'h120, 3'b000}) begin failures++; $display("FAIL async_reset got=%h tc=%b exp_o=%b run=%b exp=120 0 0 0", count, tc, expired, running); end
    #1;
    resetN = 1'b1;
  endtask

  task automatic test_random();
    logic ld, st, pt, tk, bv;
    logic [11:0] bb;
    apply(1, 1, 0, 0, 0, 12'h000);
    for (int n = 0; n < 400; n++) begin
      ld = ($urandom % 100) != 0;
      st = ($urandom % 20) == 0;
      pt = ($urandom % 10) == 0;
      tk = $urandom % 2;
      bv = ($urandom % 16) == 0;
      bb = {4'd0, 4'($urandom % 3), 4'($urandom % 11)};
      apply(ld, st, pt, tk, bv, bb);
      checks++;
      if (count !== to_bcd(m_val) || tc !== m_tc || expired !== (m_st == S_EXP) ||
          running !== (m_st == S_RUN) || warn !== m_warn()) begin
        failures++;
        $display("FAIL random[%0d] got cnt=%h tc=%b exp=%b run=%b warn=%b want cnt=%h tc=%b exp=%b run=%b warn=%b",
                 n, count, tc, expired, running, warn, to_bcd(m_val), m_tc,
                 (m_st == S_EXP), (m_st == S_RUN), m_warn());
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_borrow_warn();
    test_expiry();
    test_pause();
    test_bonus();
    test_midrun_load();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
